// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master and the SRAM slave, plus the slave's FSM state for observation.
// An address phase is accepted at an edge where HSEL && HREADY && HTRANS[1]; the data phase ends at the first edge with HREADYOUT high.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic [2:0]  dbg_state;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA, dbg_state
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA, dbg_state
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: DEPTH x 32-bit register memory, byte/halfword/word lanes,
// programmable wait states and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic               HCLK,
  input logic               HRESET,
  ahb_sram_slave_if.slave   bus
);

  localparam int          IW      = $clog2(DEPTH);
  localparam int          WS_M1   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0]  WS_LOAD = 4'(WS_M1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          r_state;
  state_t          w_go;
  logic [3:0]      r_cnt;
  logic [IW-1:0]   r_idx;
  logic [1:0]      r_lane;
  logic [1:0]      r_size;
  logic            r_write;
  logic            r_hreadyout;
  logic [1:0]      r_hresp;
  logic [31:0]     r_mem [DEPTH];
  logic [3:0]      w_be;

  wire w_accept   = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  wire w_size_bad = bus.HSIZE[2] | (bus.HSIZE[1:0] == 2'b11);
  wire w_misalign = ((bus.HSIZE == 3'b001) & bus.HADDR[0]) |
                    ((bus.HSIZE == 3'b010) & (bus.HADDR[1:0] != 2'b00));
  // BASE_ADDR is DEPTH*4 aligned, so matching upper bits covers both range limits.
  wire w_in_range = (bus.HADDR[31:IW+2] == BASE_ADDR[31:IW+2]);
  wire w_legal    = ~w_size_bad & ~w_misalign & w_in_range;
  wire w_unused_ok = ^{bus.HBURST, bus.HPROT};

  always_comb begin
    if (!w_legal)             w_go = S_ERR1;
    else if (WAIT_STATES > 0) w_go = S_WAIT;
    else                      w_go = S_DATA;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_idx       <= '0;
      r_lane      <= 2'b00;
      r_size      <= 2'b00;
      r_write     <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 2'b00;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_DATA;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 2'b01;
        end
        default: begin
          // IDLE, DATA and ERR2 all drive HREADYOUT high, so a new transfer can start here.
          if (w_accept) begin
            r_state     <= w_go;
            r_idx       <= bus.HADDR[IW+1:2];
            r_lane      <= bus.HADDR[1:0];
            r_size      <= bus.HSIZE[1:0];
            r_write     <= bus.HWRITE;
            r_cnt       <= WS_LOAD;
            r_hreadyout <= (w_go == S_DATA);
            r_hresp     <= (w_go == S_ERR1) ? 2'b01 : 2'b00;
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 2'b00;
          end
        end
      endcase
    end
  end

  always_comb begin
    case (r_size)
      2'b00:   w_be = 4'b0001 << r_lane;
      2'b01:   w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'h0;
    end else if ((r_state == S_DATA) && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  assign bus.HREADYOUT = r_hreadyout;
  assign bus.HRESP     = r_hresp;
  assign bus.HRDATA    = (r_state == S_DATA) ? r_mem[r_idx] : 32'h0;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (1 and 0 wait states) driven in turn, checked by a
// negedge monitor against a queue of expected responses from a word-array reference model.
module tb_ahb_sram_slave;
  localparam int          DEPTH = 256;
  localparam logic [31:0] B     = 32'h2000_0400;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  ahb_sram_slave_if bus0();
  ahb_sram_slave_if bus1();

  ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(1), .BASE_ADDR(B)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus0));
  ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(B)) u_dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus1));

  logic        sel;
  logic        d_hsel, d_hwrite;
  logic [31:0] d_haddr, d_hwdata;
  logic [1:0]  d_htrans;
  logic [2:0]  d_hsize, d_hburst;
  logic [3:0]  d_hprot;

  assign bus0.HSEL = d_hsel & ~sel;
  assign bus1.HSEL = d_hsel & sel;
  assign bus0.HADDR = d_haddr;   assign bus1.HADDR = d_haddr;
  assign bus0.HTRANS = d_htrans; assign bus1.HTRANS = d_htrans;
  assign bus0.HWRITE = d_hwrite; assign bus1.HWRITE = d_hwrite;
  assign bus0.HSIZE = d_hsize;   assign bus1.HSIZE = d_hsize;
  assign bus0.HBURST = d_hburst; assign bus1.HBURST = d_hburst;
  assign bus0.HPROT = d_hprot;   assign bus1.HPROT = d_hprot;
  assign bus0.HWDATA = d_hwdata; assign bus1.HWDATA = d_hwdata;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus1.HREADY = bus1.HREADYOUT;

  wire        mon_ready = sel ? bus1.HREADYOUT : bus0.HREADYOUT;
  wire [1:0]  mon_resp  = sel ? bus1.HRESP : bus0.HRESP;
  wire [31:0] mon_rdata = sel ? bus1.HRDATA : bus0.HRDATA;

  // Expected entry: [33] error response, [32] check HRDATA, [31:0] HRDATA value.
  logic [33:0] exp_q[$];
  logic [31:0] model [2][DEPTH];
  int n_checks = 0;
  int n_errors = 0;
  bit mon_active = 1'b0;
  int mon_waits = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_f(input logic [31:0] addr, input logic [2:0] size);
    if (size > 3'd2) return 1'b0;
    if (size == 3'd1 && addr % 2 != 0) return 1'b0;
    if (size == 3'd2 && addr % 4 != 0) return 1'b0;
    if (addr < B) return 1'b0;
    if ((addr - B) / 4 >= DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd);
    int idx = int'((addr - B) / 4);
    int nb = 1 << size;
    int first = (int'(addr % 4) / nb) * nb;
    for (int b = 0; b < 4; b++)
      if (b >= first && b < first + nb) model[sel][idx][8*b +: 8] = wd[8*b +: 8];
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the address phase.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                       input logic [31:0] wd, input logic [1:0] trans,
                       input bit use_k = 1'b0, input logic [31:0] k = 32'h0);
    int n = 0;
    d_hsel = 1'b1; d_haddr = addr; d_htrans = trans; d_hwrite = wr; d_hsize = size;
    d_hburst = 3'($urandom); d_hprot = 4'($urandom);
    if (!legal_f(addr, size)) exp_q.push_back({2'b11, 32'h0});
    else if (wr) begin
      model_write(addr, size, wd);
      exp_q.push_back({2'b00, 32'h0});
    end else
      exp_q.push_back({2'b01, use_k ? k : model[sel][int'((addr - B) / 4)]});
    @(negedge HCLK);
    while (!mon_ready && n < 50) begin n++; @(negedge HCLK); end
    if (n >= 50) check("accept_timeout", 64'(n), 64'(0));
    @(posedge HCLK); #1;
    d_hwdata = wd; d_hsel = 1'b0; d_htrans = 2'b00;
  endtask

  task automatic ignored_cycle(input logic hsel, input logic [1:0] trans, input logic [31:0] addr);
    d_hsel = hsel; d_htrans = trans; d_haddr = addr; d_hwrite = 1'b1; d_hsize = 3'd2;
    d_hwdata = $urandom;
    @(posedge HCLK); #1;
    d_hsel = 1'b0; d_htrans = 2'b00;
  endtask

  task automatic do_reset();
    HRESET = 1'b1; d_hsel = 1'b0; d_htrans = 2'b00;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    for (int s = 0; s < 2; s++) for (int i = 0; i < DEPTH; i++) model[s][i] = 32'h0;
    @(negedge HCLK);
    check("reset_dut0", 64'({bus0.HREADYOUT, bus0.HRESP, bus0.HRDATA, bus0.dbg_state}),
          64'({1'b1, 2'b00, 32'h0, 3'd0}));
    check("reset_dut1", 64'({bus1.HREADYOUT, bus1.HRESP, bus1.HRDATA, bus1.dbg_state}),
          64'({1'b1, 2'b00, 32'h0, 3'd0}));
    @(posedge HCLK); #1;
  endtask

  always @(negedge HCLK) begin
    logic [33:0] e;
    if (HRESET) begin
      mon_active = 1'b0;
      exp_q.delete();
    end else begin
      if (mon_active) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 64'(0), 64'(1));
          mon_active = 1'b0;
        end else if (!mon_ready) begin
          e = exp_q[0];
          mon_waits++;
          check("wait_cycle", 64'({mon_resp, mon_rdata}), 64'({e[33] ? 2'b01 : 2'b00, 32'h0}));
          if (mon_waits > 20) begin
            check("data_phase_timeout", 64'(mon_waits), 64'(0));
            void'(exp_q.pop_front());
            mon_active = 1'b0;
          end
        end else begin
          e = exp_q.pop_front();
          check("final_resp", 64'(mon_resp), 64'(e[33] ? 2'b01 : 2'b00));
          check("wait_count", 64'(mon_waits), 64'(e[33] ? 1 : (sel ? 0 : 1)));
          if (e[32]) check("rdata", 64'(mon_rdata), 64'(e[31:0]));
          mon_active = 1'b0;
        end
      end else begin
        check("idle_okay", 64'({mon_ready, mon_resp, mon_rdata}), 64'({1'b1, 2'b00, 32'h0}));
      end
      if (d_hsel && mon_ready && d_htrans[1]) begin
        mon_active = 1'b1;
        mon_waits = 0;
      end
    end
  end

  initial begin
    sel = 1'b0; d_hsel = 1'b0; d_haddr = 32'h0; d_htrans = 2'b00; d_hwrite = 1'b0;
    d_hsize = 3'd0; d_hburst = 3'd0; d_hprot = 4'd0; d_hwdata = 32'h0;
    do_reset();

    issue(B + 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 2'b10);
    issue(B + 32'h10, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1, 32'hDEADBEEF);
    issue(B + 32'h10, 1'b1, 3'd2, 32'h11223344, 2'b10);
    issue(B + 32'h13, 1'b1, 3'd0, 32'hAA00_0000, 2'b10);
    issue(B + 32'h10, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1, 32'hAA223344);
    issue(B + 32'h10, 1'b1, 3'd1, 32'h0000_5566, 2'b10);
    issue(B + 32'h10, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1, 32'hAA225566);
    issue(B + 32'h02, 1'b0, 3'd2, 32'h0, 2'b10);
    issue(B + DEPTH * 4, 1'b0, 3'd2, 32'h0, 2'b10);
    issue(B + 32'h11, 1'b1, 3'd2, 32'hFFFF_FFFF, 2'b10);
    issue(B - 32'h4, 1'b1, 3'd2, 32'hFFFF_FFFF, 2'b10);
    issue(B + 32'h10, 1'b1, 3'd3, 32'hFFFF_FFFF, 2'b10);
    issue(B + 32'h10, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1, 32'hAA225566);
    repeat (3) begin @(posedge HCLK); #1; end

    sel = 1'b1;
    issue(B + 32'h20, 1'b1, 3'd2, 32'h1, 2'b10);
    issue(B + 32'h20, 1'b0, 3'd2, 32'h0, 2'b11, 1'b1, 32'h1);
    ignored_cycle(1'b0, 2'b10, B + 32'h20);
    ignored_cycle(1'b1, 2'b01, B + 32'h20);
    ignored_cycle(1'b1, 2'b00, B + 32'h20);
    issue(B + 32'h20, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1, 32'h1);
    repeat (3) begin @(posedge HCLK); #1; end

    sel = 1'b0;
    issue(B + 32'h30, 1'b1, 3'd2, 32'hCAFEF00D, 2'b10);
    do_reset();
    issue(B + 32'h30, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1, 32'h0);
    repeat (3) begin @(posedge HCLK); #1; end

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      repeat (150) begin
        int k = $urandom_range(0, 9);
        if (k < 2) begin
          logic hs = 1'($urandom_range(0, 1));
          ignored_cycle(hs, hs ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3)),
                        B + 4 * $urandom_range(0, 15));
        end else begin
          int r = $urandom_range(0, 19);
          logic [2:0]  sz = 3'($urandom_range(0, 2));
          logic [31:0] a = B + 4 * $urandom_range(0, 15);
          if (sz == 3'd0) a = a + $urandom_range(0, 3);
          else if (sz == 3'd1) a = a + 2 * $urandom_range(0, 1);
          if (r == 0) sz = 3'($urandom_range(3, 7));
          else if (r == 1) a = B + DEPTH * 4 + 4 * $urandom_range(0, 7);
          else if (r == 2) a = B - 4 * $urandom_range(1, 4);
          else if (r == 3) begin sz = 3'd2; a = a + $urandom_range(1, 3); end
          issue(a, 1'($urandom_range(0, 1)), sz, $urandom, 2'($urandom_range(2, 3)));
          if ($urandom_range(0, 2) == 0) begin @(posedge HCLK); #1; end
        end
      end
      repeat (4) begin @(posedge HCLK); #1; end
    end

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
